// File: rtl/mprj_io_cfg_pkg.sv
// Shared types and defaults for the user-project GPIO configuration loader.
package mprj_io_cfg_pkg;

  localparam int unsigned DEF_PADS_PER_CHAIN = 19;
  localparam int unsigned DEF_CFG_BITS       = 13;
  localparam int unsigned DEF_CLK_DIV        = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } loader_state_e;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mprj_io_cfg_loader_clk_div.sv
// Divides the core clock into loader_clock half-periods: a tick ends each
// half-period and phase tracks low (0) / high (1) while phase_en is held.
module loader_clk_div
  import mprj_io_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic phase_en,
  output logic phase,
  output logic tick_c
);

  localparam int unsigned DIV_W = cnt_width(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;

  assign tick_c = run && (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      if (!run || tick_c) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      // Phase is held low outside the shift window so every bit starts low.
      if (!phase_en) begin
        phase <= 1'b0;
      end else if (tick_c) begin
        phase <= ~phase;
      end
    end
  end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Clears, serially shifts and latches the GPIO control chains from the
// SoC config register file; chain 1 sends its far pad first.
module mprj_io_cfg_loader
  import mprj_io_cfg_pkg::*;
#(
  parameter int unsigned PADS_PER_CHAIN = DEF_PADS_PER_CHAIN,
  parameter int unsigned CFG_BITS       = DEF_CFG_BITS,
  parameter int unsigned CLK_DIV        = DEF_CLK_DIV
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(2*PADS_PER_CHAIN)-1:0]   cfg_idx_1,
  output logic [$clog2(2*PADS_PER_CHAIN)-1:0]   cfg_idx_2,
  input  logic [CFG_BITS-1:0]                   cfg_word_1,
  input  logic [CFG_BITS-1:0]                   cfg_word_2,
  output logic                                  loader_resetn,
  output logic                                  loader_clock,
  output logic                                  loader_data_1,
  output logic                                  loader_data_2,
  output logic                                  loader_load
);

  localparam int unsigned IDX_W = $clog2(2 * PADS_PER_CHAIN);
  localparam int unsigned BIT_W = cnt_width(CFG_BITS);
  localparam int unsigned PAD_W = cnt_width(PADS_PER_CHAIN);

  loader_state_e       state;
  logic [BIT_W-1:0]    bit_cnt;
  logic [PAD_W-1:0]    pad_cnt;
  logic [CFG_BITS-1:0] shift_1;
  logic [CFG_BITS-1:0] shift_2;

  logic run_c;
  logic phase_en_c;
  logic phase;
  logic tick_c;
  logic word_end_c;
  logic last_pad_c;

  assign run_c      = (state == CLEAR) || (state == SHIFT) || (state == LOAD);
  assign phase_en_c = (state == SHIFT);
  assign word_end_c = (bit_cnt == BIT_W'(CFG_BITS - 1));
  assign last_pad_c = (pad_cnt == PAD_W'(PADS_PER_CHAIN - 1));

  loader_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .run      (run_c),
    .phase_en (phase_en_c),
    .phase    (phase),
    .tick_c   (tick_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_idx_1     <= '0;
      cfg_idx_2     <= '0;
      bit_cnt       <= '0;
      pad_cnt       <= '0;
      shift_1       <= '0;
      shift_2       <= '0;
      loader_resetn <= 1'b1;
      loader_clock  <= 1'b0;
      loader_data_1 <= 1'b0;
      loader_data_2 <= 1'b0;
      loader_load   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= CLEAR;
            busy          <= 1'b1;
            loader_resetn <= 1'b0;
            bit_cnt       <= '0;
            pad_cnt       <= '0;
            cfg_idx_1     <= IDX_W'(PADS_PER_CHAIN - 1);
            cfg_idx_2     <= IDX_W'(PADS_PER_CHAIN);
          end
        end

        // Leaving the clear drives the first bit of word 0.
        CLEAR: begin
          if (tick_c) begin
            state         <= SHIFT;
            loader_resetn <= 1'b1;
            shift_1       <= cfg_word_1;
            shift_2       <= cfg_word_2;
            loader_data_1 <= cfg_word_1[CFG_BITS-1];
            loader_data_2 <= cfg_word_2[CFG_BITS-1];
            if (!last_pad_c) begin
              cfg_idx_1 <= cfg_idx_1 - IDX_W'(1);
              cfg_idx_2 <= cfg_idx_2 + IDX_W'(1);
            end
          end
        end

        // Rising edge mid-bit; data moves only when the high phase ends.
        SHIFT: begin
          if (tick_c) begin
            if (!phase) begin
              loader_clock <= 1'b1;
            end else begin
              loader_clock <= 1'b0;
              if (word_end_c) begin
                bit_cnt <= '0;
                if (last_pad_c) begin
                  state         <= LOAD;
                  loader_load   <= 1'b1;
                  loader_data_1 <= 1'b0;
                  loader_data_2 <= 1'b0;
                end else begin
                  pad_cnt       <= pad_cnt + PAD_W'(1);
                  shift_1       <= cfg_word_1;
                  shift_2       <= cfg_word_2;
                  loader_data_1 <= cfg_word_1[CFG_BITS-1];
                  loader_data_2 <= cfg_word_2[CFG_BITS-1];
                  // The index for the following word is only needed if one exists.
                  if (pad_cnt != PAD_W'(PADS_PER_CHAIN - 2)) begin
                    cfg_idx_1 <= cfg_idx_1 - IDX_W'(1);
                    cfg_idx_2 <= cfg_idx_2 + IDX_W'(1);
                  end
                end
              end else begin
                bit_cnt       <= bit_cnt + BIT_W'(1);
                shift_1       <= {shift_1[CFG_BITS-2:0], shift_1[CFG_BITS-1]};
                shift_2       <= {shift_2[CFG_BITS-2:0], shift_2[CFG_BITS-1]};
                loader_data_1 <= shift_1[CFG_BITS-2];
                loader_data_2 <= shift_2[CFG_BITS-2];
              end
            end
          end
        end

        LOAD: begin
          if (tick_c) begin
            state       <= DONE;
            loader_load <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          cfg_idx_1 <= '0;
          cfg_idx_2 <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Directed bench for mprj_io_cfg_loader: sequence timing, chain contents,
// ignored restarts, mid-shift reset, CLK_DIV=1 and back-to-back starts.
module tb_mprj_io_cfg_loader;
  import mprj_io_cfg_pkg::*;

  localparam int unsigned N  = DEF_PADS_PER_CHAIN;
  localparam int unsigned CB = DEF_CFG_BITS;
  localparam int unsigned IW = $clog2(2 * N);
  localparam int unsigned NB = N * CB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic          busy0, done0, rn0, lclk0, d1_0, d2_0, ld0;
  logic [IW-1:0] idx1_0, idx2_0;
  logic [CB-1:0] word1_0, word2_0;
  logic          busy1, done1, rn1, lclk1, d1_1, d2_1, ld1;
  logic [IW-1:0] idx1_1, idx2_1;
  logic [CB-1:0] word1_1, word2_1;

  int checks = 0;
  int errors = 0;

  // Register-file model: pad i holds i | (i << 8), truncated to CB bits.
  function automatic logic [CB-1:0] pad_word(input logic [IW-1:0] i);
    return CB'(16'(i) | (16'(i) << 8));
  endfunction

  assign word1_0 = pad_word(idx1_0);
  assign word2_0 = pad_word(idx2_0);
  assign word1_1 = pad_word(idx1_1);
  assign word2_1 = pad_word(idx2_1);

  mprj_io_cfg_loader #(.PADS_PER_CHAIN(N), .CFG_BITS(CB), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .cfg_idx_1(idx1_0), .cfg_idx_2(idx2_0), .cfg_word_1(word1_0), .cfg_word_2(word2_0),
    .loader_resetn(rn0), .loader_clock(lclk0), .loader_data_1(d1_0),
    .loader_data_2(d2_0), .loader_load(ld0)
  );

  mprj_io_cfg_loader #(.PADS_PER_CHAIN(N), .CFG_BITS(CB), .CLK_DIV(1)) dut_div1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .cfg_idx_1(idx1_1), .cfg_idx_2(idx2_1), .cfg_word_1(word1_1), .cfg_word_2(word2_1),
    .loader_resetn(rn1), .loader_clock(lclk1), .loader_data_1(d1_1),
    .loader_data_2(d2_1), .loader_load(ld1)
  );

  typedef struct {
    string name;
    int    restart_a;
    int    restart_b;
    int    abort_at;
    int    exp_done_rel;
    int    exp_busy_cycles;
    int    exp_rises;
    int    exp_rn_low;
    int    exp_load_cycles;
    int    exp_load_last;
    int    exp_dones;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Chain 1 sends pad N-1 first, so pad p ends at slot p; chain 2 sends pad N first.
  task automatic check_words(input string tag, input logic [NB-1:0] c1, input logic [NB-1:0] c2);
    for (int p = 0; p < int'(N); p++) begin
      check($sformatf("%s chain1 pad %0d", tag, p), 64'(c1[p*CB +: CB]), 64'(pad_word(IW'(p))));
      check($sformatf("%s chain2 pad %0d", tag, int'(N) + p),
            64'(c2[(int'(N) - 1 - p)*CB +: CB]), 64'(pad_word(IW'(int'(N) + p))));
    end
  endtask

  task automatic run_row(input vec_t v);
    int rel = 0, done_rel = 0, busy_n = 0, rises = 0, rn_low = 0, rn_first = 0;
    int ld_n = 0, ld_last = 0, dones = 0;
    logic prev_clk = 1'b0, prev_ld = 1'b0;
    logic [NB-1:0] ch1 = '0, ch2 = '0, lat1 = '0, lat2 = '0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      rel = k + 1;
      if (rel == 1) check({v.name, " busy_at_T+1"}, 64'(busy0), 64'd1);
      if (busy0) busy_n++;
      if (!rn0) begin
        rn_low++;
        ch1 = '0;
        ch2 = '0;
        if (rn_first == 0) rn_first = rel;
      end
      if (lclk0 && !prev_clk) begin
        rises++;
        ch1 = {ch1[NB-2:0], d1_0};
        ch2 = {ch2[NB-2:0], d2_0};
      end
      if (ld0) begin
        ld_n++;
        ld_last = rel;
        if (!prev_ld) begin
          lat1 = ch1;
          lat2 = ch2;
        end
      end
      if (done0) begin
        dones++;
        done_rel = rel;
      end
      prev_clk = lclk0;
      prev_ld  = ld0;
      start0 = (rel == v.restart_a) || (rel == v.restart_b);
      if (rel == v.abort_at) begin
        start0 = 1'b0;
        reset = 1'b1;
        #1;
        check({v.name, " outputs_on_reset"},
              64'({busy0, done0, rn0, lclk0, d1_0, d2_0, ld0, idx1_0, idx2_0}),
              64'({7'b0010000, IW'(0), IW'(0)}));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        break;
      end
      if (done_rel != 0 && rel == done_rel + 3) break;
      @(negedge clk);
    end
    start0 = 1'b0;
    check({v.name, " done_rel"},     64'(done_rel), 64'(v.exp_done_rel));
    check({v.name, " done_count"},   64'(dones),    64'(v.exp_dones));
    check({v.name, " busy_cycles"},  64'(busy_n),   64'(v.exp_busy_cycles));
    check({v.name, " clock_rises"},  64'(rises),    64'(v.exp_rises));
    check({v.name, " resetn_low"},   64'(rn_low),   64'(v.exp_rn_low));
    check({v.name, " resetn_first"}, 64'(rn_first), 64'd1);
    check({v.name, " load_cycles"},  64'(ld_n),     64'(v.exp_load_cycles));
    check({v.name, " load_last"},    64'(ld_last),  64'(v.exp_load_last));
    if (v.exp_load_cycles != 0) check_words(v.name, lat1, lat2);
  endtask

  // Pulses start0 for one cycle if requested, then returns T-relative done time (0 = none).
  task automatic wait_done0(output int rel);
    rel = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) begin
        rel = k + 1;
        return;
      end
    end
  endtask

  task automatic run_div1();
    int done_rel = 0, dones = 0, rises = 0, hi_run = 0, hi_max = 0, lo_run = 0, lo_max = 0;
    logic prev_clk = 1'b0, prev_ld = 1'b0;
    logic [NB-1:0] ch1 = '0, ch2 = '0, lat1 = '0, lat2 = '0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (!rn1) begin
        ch1 = '0;
        ch2 = '0;
      end
      if (lclk1) begin
        if (!prev_clk) begin
          if (rises > 0 && lo_run > lo_max) lo_max = lo_run;
          rises++;
          ch1 = {ch1[NB-2:0], d1_1};
          ch2 = {ch2[NB-2:0], d2_1};
        end
        hi_run++;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_run = 0;
      end else begin
        hi_run = 0;
        lo_run++;
      end
      if (ld1 && !prev_ld) begin
        lat1 = ch1;
        lat2 = ch2;
      end
      if (done1) begin
        dones++;
        done_rel = k + 1;
      end
      prev_clk = lclk1;
      prev_ld  = ld1;
      if (done_rel != 0 && k + 1 == done_rel + 2) break;
      @(negedge clk);
    end
    check("div1 done_rel",    64'(done_rel), 64'd497);
    check("div1 done_count",  64'(dones),    64'd1);
    check("div1 clock_rises", 64'(rises),    64'd247);
    check("div1 high_run",    64'(hi_max),   64'd1);
    check("div1 low_run",     64'(lo_max),   64'd1);
    check_words("div1", lat1, lat2);
  endtask

  initial begin
    int d;
    vecs[0] = '{"normal",        0,   0,   0, 993, 992, 247, 2, 2, 992, 1};
    vecs[1] = '{"restarts",      100, 500, 0, 993, 992, 247, 2, 2, 992, 1};
    vecs[2] = '{"abort",         0,   0, 400,   0, 400,  99, 2, 0,   0, 0};
    vecs[3] = '{"after_abort",   0,   0,   0, 993, 992, 247, 2, 2, 992, 1};

    #2 reset = 1'b1;
    #1;
    check("reset_state dut", 64'({busy0, done0, rn0, lclk0, d1_0, d2_0, ld0, idx1_0, idx2_0}),
          64'({7'b0010000, IW'(0), IW'(0)}));
    check("reset_state dut_div1", 64'({busy1, done1, rn1, lclk1, d1_1, d2_1, ld1, idx1_1, idx2_1}),
          64'({7'b0010000, IW'(0), IW'(0)}));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_row(vecs[i]);

    run_div1();

    // Start during DONE must be dropped; start one cycle later must launch a run.
    @(negedge clk);
    start0 = 1'b1;
    wait_done0(d);
    check("b2b first done_rel", 64'(d), 64'd993);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("b2b start_in_done ignored", 64'(busy0), 64'd0);
    @(negedge clk);
    check("b2b still idle", 64'(busy0), 64'd0);
    start0 = 1'b1;
    wait_done0(d);
    check("b2b second done_rel", 64'(d), 64'd993);
    @(negedge clk);
    start0 = 1'b1;
    wait_done0(d);
    check("b2b start_after_done done_rel", 64'(d), 64'd993);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
